// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants for the fetch-PC controller: reset/exception addresses,
// FSM state encoding and redirect-source priority codes (larger = higher priority).
package pc_fetch_ctrl_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [2:0] SRC_SEQ  = 3'd0;
  localparam logic [2:0] SRC_BR   = 3'd1;
  localparam logic [2:0] SRC_J    = 3'd2;
  localparam logic [2:0] SRC_JR   = 3'd3;
  localparam logic [2:0] SRC_ERET = 3'd4;
  localparam logic [2:0] SRC_EXC  = 3'd5;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_npc_mux.sv
// Combinational next-PC priority selector: returns the winning target and
// its source code (exception > eret > jr > j > branch > sequential).
module npc_mux
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [31:0] pc_plus4,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        j_valid,
  input  logic [31:0] j_target,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        exc_req,
  output logic [31:0] target,
  output logic [2:0]  src
);

  always_comb begin
    target = pc_plus4;
    src    = SRC_SEQ;
    if (exc_req) begin
      target = EXC_VECTOR;
      src    = SRC_EXC;
    end else if (eret) begin
      target = epc;
      src    = SRC_ERET;
    end else if (jr_valid) begin
      target = jr_target;
      src    = SRC_JR;
    end else if (j_valid) begin
      target = j_target;
      src    = SRC_J;
    end else if (br_taken) begin
      target = br_target;
      src    = SRC_BR;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and next-PC controller with one-deep redirect queue during stalls.
// Optional macro PC_ALIGN_CHECK_EN: misaligned targets trap to EXC_VECTOR with adel_o.
//
// state | meaning
// RUN   | normal fetch; PC advances or redirects unless stalled
// HOLD  | stalled with a redirect parked in pend_pc
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = PC_RESET_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        j_valid_i,
  input  logic [31:0] j_target_i,
  input  logic        jr_valid_i,
  input  logic [31:0] jr_target_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        exc_req_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] pc_plus8_o,
  output logic        redirect_o,
  output logic        adel_o
);

  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic [2:0]  pend_src_q;
  logic [0:0]  state_q;
  logic        redirect_q;
  logic        adel_q;

  logic [31:0] sel_target;
  logic [2:0]  sel_src;
  logic [31:0] apply_target;
  logic        apply_redirect;
  logic        load_pc;
  logic [31:0] load_val;
  logic        load_adel;

  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_q + 32'd4;
  assign pc_plus8_o = pc_q + 32'd8;
  assign redirect_o = redirect_q;
  assign adel_o     = adel_q;

  npc_mux #(.EXC_VECTOR(EXC_VECTOR)) u_npc_mux (
    .pc_plus4  (pc_plus4_o),
    .br_taken  (br_taken_i),
    .br_target (br_target_i),
    .j_valid   (j_valid_i),
    .j_target  (j_target_i),
    .jr_valid  (jr_valid_i),
    .jr_target (jr_target_i),
    .eret      (eret_i),
    .epc       (epc_i),
    .exc_req   (exc_req_i),
    .target    (sel_target),
    .src       (sel_src)
  );

  // In HOLD the parked target wins unless a strictly higher-priority request shows up.
  always_comb begin
    apply_target   = sel_target;
    apply_redirect = (sel_src != SRC_SEQ);
    if ((state_q == ST_HOLD) && !(sel_src > pend_src_q)) begin
      apply_target   = pend_pc_q;
      apply_redirect = 1'b1;
    end
    load_pc = !stall_i || (sel_src == SRC_EXC);
`ifdef PC_ALIGN_CHECK_EN
    load_adel = (apply_target[1:0] != 2'b00);
    load_val  = load_adel ? EXC_VECTOR : apply_target;
`else
    load_adel = 1'b0;
    load_val  = word_align(apply_target);
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'd0;
      pend_src_q <= SRC_SEQ;
      state_q    <= ST_RUN;
      redirect_q <= 1'b0;
      adel_q     <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      adel_q     <= 1'b0;
      if (load_pc) begin
        pc_q       <= load_val;
        redirect_q <= apply_redirect;
        adel_q     <= load_adel;
        pend_pc_q  <= 32'd0;
        pend_src_q <= SRC_SEQ;
        state_q    <= ST_RUN;
      end else if ((sel_src != SRC_SEQ) &&
                   ((state_q == ST_RUN) || (sel_src > pend_src_q))) begin
        pend_pc_q  <= sel_target;
        pend_src_q <= sel_src;
        state_q    <= ST_HOLD;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: stimulus pushes per-cycle expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic        br_taken_i;
  logic [31:0] br_target_i;
  logic        j_valid_i;
  logic [31:0] j_target_i;
  logic        jr_valid_i;
  logic [31:0] jr_target_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic        exc_req_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic [31:0] pc_plus8_o;
  logic        redirect_o;
  logic        adel_o;

  pc_fetch_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall_i     (stall_i),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .j_valid_i   (j_valid_i),
    .j_target_i  (j_target_i),
    .jr_valid_i  (jr_valid_i),
    .jr_target_i (jr_target_i),
    .eret_i      (eret_i),
    .epc_i       (epc_i),
    .exc_req_i   (exc_req_i),
    .pc_o        (pc_o),
    .pc_plus4_o  (pc_plus4_o),
    .pc_plus8_o  (pc_plus8_o),
    .redirect_o  (redirect_o),
    .adel_o      (adel_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic        red;
    logic        adel;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_o", pc_o, e.pc);
      chk("pc_plus4_o", pc_plus4_o, e.pc + 32'd4);
      chk("pc_plus8_o", pc_plus8_o, e.pc + 32'd8);
      chk("redirect_o", {31'd0, redirect_o}, {31'd0, e.red});
      chk("adel_o", {31'd0, adel_o}, {31'd0, e.adel});
    end
  end

  task automatic push(input logic [31:0] pc, input logic red, input logic adel);
    exp_t e;
    e.pc = pc; e.red = red; e.adel = adel;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    stall_i = 0; br_taken_i = 0; br_target_i = 0; j_valid_i = 0; j_target_i = 0;
    jr_valid_i = 0; jr_target_i = 0; eret_i = 0; epc_i = 0; exc_req_i = 0;
  endtask

  // kind: 0 none, 1 br, 2 j, 3 jr, 4 eret, 5 exc; kind2 adds a second request
  task automatic step(input logic stall, input int kind, input logic [31:0] tgt,
                      input int kind2, input logic [31:0] tgt2,
                      input logic [31:0] exp_pc, input logic exp_red, input logic exp_adel);
    @(negedge clk);
    idle_inputs();
    stall_i = stall;
    for (int k = 0; k < 2; k++) begin
      int          kk;
      logic [31:0] tt;
      kk = (k == 0) ? kind : kind2;
      tt = (k == 0) ? tgt : tgt2;
      case (kk)
        1: begin br_taken_i = 1; br_target_i = tt; end
        2: begin j_valid_i = 1; j_target_i = tt; end
        3: begin jr_valid_i = 1; jr_target_i = tt; end
        4: begin eret_i = 1; epc_i = tt; end
        5: exc_req_i = 1;
        default: ;
      endcase
    end
    push(exp_pc, exp_red, exp_adel);
  endtask

  initial begin
    logic [31:0] mis_pc;
    logic        mis_adel;
`ifdef PC_ALIGN_CHECK_EN
    mis_pc = 32'h0000_4180; mis_adel = 1'b1;
`else
    mis_pc = 32'h0000_3100; mis_adel = 1'b0;
`endif
    idle_inputs();
    reset_n = 1'b0;
    @(posedge clk);
    #2;
    chk("reset pc_o", pc_o, 32'h0000_3000);
    chk("reset pc_plus4_o", pc_plus4_o, 32'h0000_3004);
    chk("reset pc_plus8_o", pc_plus8_o, 32'h0000_3008);
    chk("reset redirect_o", {31'd0, redirect_o}, 32'd0);
    chk("reset adel_o", {31'd0, adel_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    push(32'h0000_3004, 0, 0);

    step(0, 0, 0, 0, 0, 32'h0000_3008, 0, 0);
    step(0, 1, 32'h0000_3100, 0, 0, 32'h0000_3100, 1, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3104, 0, 0);
    // stalled jump parked, applied on release
    step(1, 2, 32'h0000_3200, 0, 0, 32'h0000_3104, 0, 0);
    step(1, 0, 0, 0, 0, 32'h0000_3104, 0, 0);
    step(1, 0, 0, 0, 0, 32'h0000_3104, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3200, 1, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3204, 0, 0);
    step(0, 2, 32'h0000_3200, 3, 32'h0000_3300, 32'h0000_3300, 1, 0);
    step(1, 0, 0, 0, 0, 32'h0000_3300, 0, 0);
    // pending replacement only by strictly higher priority
    step(1, 1, 32'h0000_3500, 0, 0, 32'h0000_3300, 0, 0);
    step(1, 3, 32'h0000_3600, 0, 0, 32'h0000_3300, 0, 0);
    step(1, 1, 32'h0000_3700, 0, 0, 32'h0000_3300, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3600, 1, 0);
    // exception overrides stall and drops pending
    step(1, 2, 32'h0000_3800, 0, 0, 32'h0000_3600, 0, 0);
    step(1, 5, 0, 0, 0, 32'h0000_4180, 1, 0);
    step(0, 0, 0, 0, 0, 32'h0000_4184, 0, 0);
    // higher-priority request on release beats pending
    step(1, 1, 32'h0000_3900, 0, 0, 32'h0000_4184, 0, 0);
    step(0, 3, 32'h0000_3A00, 0, 0, 32'h0000_3A00, 1, 0);
    step(0, 4, 32'h0000_5000, 3, 32'h0000_6000, 32'h0000_5000, 1, 0);
    // wrap-around
    step(0, 3, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 0);
    step(0, 0, 0, 0, 0, 32'h0000_0000, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_0004, 0, 0);
    // misaligned branch target
    step(0, 1, 32'h0000_3102, 0, 0, mis_pc, 1, mis_adel);
    step(0, 0, 0, 0, 0, mis_pc + 32'd4, 0, 0);
    // reset while a redirect is parked
    step(1, 2, 32'h0000_7000, 0, 0, mis_pc + 32'd4, 0, 0);
    @(negedge clk);
    idle_inputs();
    stall_i = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midhold reset pc_o", pc_o, 32'h0000_3000);
    chk("midhold reset redirect_o", {31'd0, redirect_o}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stall_i = 1'b0;
    push(32'h0000_3004, 0, 0);
    step(0, 0, 0, 0, 0, 32'h0000_3008, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
